// File: rtl/decodificador_hamming_pkg.sv
// Shared Hamming(15,11) constants: codeword/data/syndrome widths, the data-bit
// position map, and the output word bundle used by the decoder pipeline.
package decodificador_hamming_pkg;

    localparam int CW_W   = 15;
    localparam int DATA_W = 11;
    localparam int SIND_W = 4;

    typedef logic [SIND_W-1:0] idx_t;

    // Codeword indices that carry data, ascending; entry k feeds dado[k].
    localparam idx_t DATA_IDX [DATA_W] = '{
        4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14
    };

    typedef struct packed {
        logic [DATA_W-1:0] dado;
        logic [SIND_W-1:0] sindrome;
        logic              corrigido;
    } saida_t;

    function automatic logic [DATA_W-1:0] extrai_dado(input logic [CW_W-1:0] cw);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int k = 0; k < DATA_W; k++) begin
            d[k] = cw[DATA_IDX[k]];
        end
        return d;
    endfunction

endpackage

// File: rtl/hamming_sindrome.sv
// Combinational Hamming(15,11) syndrome generator and single-bit corrector.
// The syndrome side serves the incoming word; the corrector side serves stage 1.
module hamming_sindrome
    import decodificador_hamming_pkg::*;
(
    input  logic [CW_W-1:0]   palavra,
    output logic [SIND_W-1:0] sindrome,
    input  logic [CW_W-1:0]   palavra_reg,
    input  logic [SIND_W-1:0] sind_reg,
    output logic [CW_W-1:0]   corrigida
);

    logic [CW_W-1:0] mascara;

    // Syndrome is the XOR of the 1-based positions of every set bit.
    always_comb begin
        sindrome = '0;
        for (int i = 0; i < CW_W; i++) begin
            if (palavra[i]) begin
                sindrome = sindrome ^ SIND_W'(i + 1);
            end
        end
    end

    always_comb begin
        mascara = '0;
        if (sind_reg != '0) begin
            mascara[sind_reg - 4'd1] = 1'b1;
        end
    end

    assign corrigida = palavra_reg ^ mascara;

endmodule

// File: rtl/decodificador_hamming.sv
// Two-stage Hamming(15,11) decoder with valid/ready on both sides and a
// saturating count of corrected words delivered downstream.
module decodificador_hamming
    import decodificador_hamming_pkg::*;
#(
    parameter int CONT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CW_W-1:0]   entrada,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] dado,
    output logic [SIND_W-1:0] sindrome,
    output logic              corrigido,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              limpa_cont,
    output logic [CONT_W-1:0] cont_erros
);

    // Handshake: a word moves on a rising edge where valid and ready are both
    // high; the producer keeps valid and data steady until that edge.
    logic              s1_valid;
    logic [CW_W-1:0]   s1_palavra;
    logic [SIND_W-1:0] s1_sind;
    logic [SIND_W-1:0] sind_entrada;
    logic [CW_W-1:0]   s1_corrigida;
    logic              s2_load;

    hamming_sindrome u_sindrome (
        .palavra     (entrada),
        .sindrome    (sind_entrada),
        .palavra_reg (s1_palavra),
        .sind_reg    (s1_sind),
        .corrigida   (s1_corrigida)
    );

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_palavra <= '0;
            s1_sind    <= '0;
            out_valid  <= 1'b0;
            dado       <= '0;
            sindrome   <= '0;
            corrigido  <= 1'b0;
        end else begin
            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    dado      <= extrai_dado(s1_corrigida);
                    sindrome  <= s1_sind;
                    corrigido <= (s1_sind != '0);
                end
            end
            // When in_ready is high stage 1 is either empty or draining this edge.
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_palavra <= entrada;
                    s1_sind    <= sind_entrada;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cont_erros <= '0;
        end else if (limpa_cont) begin
            cont_erros <= '0;
        end else if (out_valid && out_ready && corrigido && (cont_erros != '1)) begin
            cont_erros <= cont_erros + 1'b1;
        end
    end

endmodule

// File: tb/tb_decodificador_hamming.sv
// Directed bench for decodificador_hamming: driver tasks push expected outputs
// into a queue, a negedge monitor pops and compares on each output transfer.
module tb_decodificador_hamming;
    import decodificador_hamming_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] entrada;
    logic        in_valid;
    logic        in_ready, in_ready2;
    logic [10:0] dado, dado2;
    logic [3:0]  sindrome, sindrome2;
    logic        corrigido, corrigido2;
    logic        out_valid, out_valid2;
    logic        out_ready;
    logic        limpa_cont;
    logic [15:0] cont_erros;
    logic [1:0]  cont_erros2;

    logic [15:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    decodificador_hamming u_dut (
        .clk(clk), .rst(rst), .entrada(entrada), .in_valid(in_valid),
        .in_ready(in_ready), .dado(dado), .sindrome(sindrome),
        .corrigido(corrigido), .out_valid(out_valid), .out_ready(out_ready),
        .limpa_cont(limpa_cont), .cont_erros(cont_erros)
    );

    decodificador_hamming #(.CONT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .entrada(entrada), .in_valid(in_valid),
        .in_ready(in_ready2), .dado(dado2), .sindrome(sindrome2),
        .corrigido(corrigido2), .out_valid(out_valid2), .out_ready(out_ready),
        .limpa_cont(limpa_cont), .cont_erros(cont_erros2)
    );

    task automatic check(input string nome, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nome, act, req);
        end
    endtask

    // Monitor: compares every output transfer and checks hold stability.
    logic        held = 1'b0;
    logic [15:0] held_val;
    always @(negedge clk) begin
        logic [15:0] e;
        #2;
        if (!rst && out_valid) begin
            if (held) check("stable_hold", {dado, sindrome, corrigido}, held_val);
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got dado %0h with empty queue", dado);
                end else begin
                    e = exp_q.pop_front();
                    check("dado", dado, e[15:5]);
                    check("sindrome", sindrome, e[4:1]);
                    check("corrigido", corrigido, e[0]);
                end
            end
            held_val = {dado, sindrome, corrigido};
            held = !out_ready;
        end else begin
            held = 1'b0;
        end
    end

    task automatic send(input logic [14:0] w, input logic [15:0] e, output int espera);
        entrada  = w;
        in_valid = 1'b1;
        espera   = 0;
        #1;
        while (!in_ready && espera < 40) begin
            @(negedge clk);
            #1;
            espera++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready still 0 after %0d cycles", espera);
        end else begin
            @(posedge clk);
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            #3;
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1; entrada = '0; in_valid = 1'b0; out_ready = 1'b1; limpa_cont = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_dado", dado, 0);
        check("rst_sindrome", sindrome, 0);
        check("rst_corrigido", corrigido, 0);
        check("rst_cont", cont_erros, 0);
        check("rst_cont2", cont_erros2, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Clean zero codeword and its latency.
        send(15'h0000, {11'h000, 4'd0, 1'b0}, w);
        idle();
        #1 check("lat_edge1_out_valid", out_valid, 0);
        @(negedge clk);
        #1 check("lat_edge2_out_valid", out_valid, 1);
        drain();
        check("cont_after_clean", cont_erros, 0);

        // 0x5A5 encodes to 0x5A25; index 5 flipped gives 0x5A05.
        send(15'h5A05, {11'h5A5, 4'd6, 1'b1}, w);
        idle();
        drain();
        check("cont_after_5a5", cont_erros, 1);

        // All 15 single-bit flips, back to back.
        for (int n = 0; n < 15; n++) begin
            send(15'h5A25 ^ (15'd1 << n), {11'h5A5, 4'(n + 1), 1'b1}, w);
            check("sweep_no_wait", w, 0);
        end
        idle();
        drain();
        check("cont_after_sweep", cont_erros, 16);
        check("cont2_saturated", cont_erros2, 3);

        // Backpressure: two words fill the pipe, third must wait.
        out_ready = 1'b0;
        send(15'h5A25, {11'h5A5, 4'd0, 1'b0}, w);
        send(15'h0008, {11'h000, 4'd4, 1'b1}, w);
        entrada  = 15'h1A25;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 check("bp_in_ready_low", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_dado_first", dado, 11'h5A5);
            @(negedge clk);
        end
        out_ready = 1'b1;
        send(15'h1A25, {11'h5A5, 4'd15, 1'b1}, w);
        idle();
        drain();
        check("cont_after_bp", cont_erros, 18);

        // Clear, then saturation of the 2-bit counter.
        limpa_cont = 1'b1;
        @(negedge clk);
        limpa_cont = 1'b0;
        #1 check("clear_cont", cont_erros, 0);
        check("clear_cont2", cont_erros2, 0);
        for (int i = 0; i < 5; i++) begin
            send(15'h0001 << i, {11'h000, 4'(i + 1), 1'b1}, w);
        end
        idle();
        drain();
        check("cont_after_5", cont_erros, 5);
        check("cont2_hold_at_3", cont_erros2, 3);

        // Clear on the same edge as a corrected transfer.
        out_ready = 1'b0;
        send(15'h0040, {11'h000, 4'd7, 1'b1}, w);
        idle();
        repeat (2) @(negedge clk);
        #1 check("clr_xfer_out_valid", out_valid, 1);
        limpa_cont = 1'b1;
        out_ready  = 1'b1;
        @(negedge clk);
        limpa_cont = 1'b0;
        #1 check("clr_xfer_cont", cont_erros, 0);
        check("clr_xfer_cont2", cont_erros2, 0);
        drain();

        // Reset with two words in flight.
        send(15'h5A05, {11'h5A5, 4'd6, 1'b1}, w);
        idle();
        drain();
        check("cont_before_rst", cont_erros, 1);
        out_ready = 1'b0;
        send(15'h5A25, {11'h5A5, 4'd0, 1'b0}, w);
        send(15'h0002, {11'h000, 4'd2, 1'b1}, w);
        idle();
        rst = 1'b1;
        #1 check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_cont", cont_erros, 0);
        check("midrst_cont2", cont_erros2, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        send(15'h0000, {11'h000, 4'd0, 1'b0}, w);
        idle();
        #1 check("post_rst_lat1", out_valid, 0);
        @(negedge clk);
        #1 check("post_rst_lat2", out_valid, 1);
        drain();
        check("post_rst_cont", cont_erros, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decodificador_hamming.md
DECODIFICADOR_HAMMING -- requirements
Module: decodificador_hamming

Interface
REQ-001 The block SHALL have parameter CONT_W, default 16, giving the width of the corrected-error counter.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port entrada  input  15  received Hamming(15,11) codeword, possibly with one flipped bit.
REQ-005 The block SHALL have port in_valid  input  1  entrada holds a word.
REQ-006 The block SHALL have port in_ready  output  1  block accepts entrada this cycle.
REQ-007 The block SHALL have port dado  output  11  decoded and corrected data bits.
REQ-008 The block SHALL have port sindrome  output  4  syndrome of the word on dado.
REQ-009 The block SHALL have port corrigido  output  1  a bit was flipped to produce dado.
REQ-010 The block SHALL have port out_valid  output  1  dado, sindrome and corrigido are valid.
REQ-011 The block SHALL have port out_ready  input  1  downstream accepts the output.
REQ-012 The block SHALL have port limpa_cont  input  1  synchronous clear of cont_erros.
REQ-013 The block SHALL have port cont_erros  output  CONT_W  count of corrected words delivered, saturating.

Function
REQ-014 Codeword bit index i (0..14) SHALL be Hamming position i+1: parity at indices 0,1,3,7; data at indices 2,4,5,6,8,9,10,11,12,13,14, mapped in ascending order to dado[0]..dado[10].
REQ-015 Syndrome SHALL be the XOR of (i+1) over all indices i where entrada[i]=1, 4 bits wide.
REQ-016 Syndrome 0 SHALL give corrigido=0 and no change; syndrome s in 1..15 SHALL flip bit index s-1 before extraction and give corrigido=1.
REQ-017 Stage 1 SHALL register entrada and its syndrome; stage 2 SHALL register the corrected dado, sindrome and corrigido; latency SHALL be 2 cycles from acceptance to out_valid with no backpressure.
REQ-018 A transfer SHALL occur on a rising edge where valid and ready are both 1, on either side.
REQ-019 Stage 2 SHALL load when empty or when out_ready=1; stage 1 SHALL advance into stage 2 under the same condition.
REQ-020 in_ready SHALL equal (stage 1 empty) OR (stage 2 loads this cycle); it SHALL be combinational from out_ready with no path from in_valid.
REQ-021 While out_valid=1 and out_ready=0, dado, sindrome and corrigido SHALL hold stable.
REQ-022 Full throughput SHALL be one word per cycle when out_ready stays 1; with out_ready=0, at most 2 words SHALL be held, and after that in_ready=0.
REQ-023 cont_erros SHALL increment by 1 on each output transfer with corrigido=1; at all-ones it SHALL saturate.
REQ-024 If limpa_cont=1, cont_erros SHALL become 0 on that edge, even when an increment happens on the same edge.

Reset
REQ-025 While rst=1, both stage valid flags, out_valid, dado, sindrome, corrigido and cont_erros SHALL be 0, and in_ready SHALL be 1.
REQ-026 Reset asserted during operation SHALL discard in-flight words with no output transfer; the first word accepted after release SHALL appear 2 cycles later.

Structure
REQ-027 A shared package SHALL hold the codeword width (15), data width (11), syndrome width (4) and the data-index map of REQ-014, for use here and by the injector bench.
REQ-028 The syndrome and correction logic SHALL be one combinational sub-module, hamming_sindrome, computing syndrome and corrected codeword; pipeline, handshake and counter stay in the top.

Verification
REQ-029 Bench: clean encoding of data 11'h000 -> dado=000, sindrome=0, corrigido=0, out_valid 2 cycles after acceptance.
REQ-030 Bench: valid codeword for data 11'h5A5 with bit index 5 flipped (injector n=5) -> dado=5A5, sindrome=6, corrigido=1, cont_erros=1.
REQ-031 Bench: sweep all 15 single-bit flips of one codeword with out_ready=1 -> 15 outputs on consecutive cycles, sindrome=n+1 each, cont_erros=15.
REQ-032 Bench: hold out_ready=0 and present 3 words -> first 2 accepted, in_ready=0 after that, output stable; release -> words out in order.
REQ-033 Bench: CONT_W=2, send 5 corrected words -> cont_erros stays at 3; limpa_cont together with a corrected transfer -> 0.
REQ-034 Bench: assert rst with 2 words in flight -> out_valid=0 at once, no transfer, cont_erros=0.
